reg_file_read_port_pair: RTL and testbench

- Register file with 2^A entries of W bits, one synchronous write port and two independent registered read ports.
- Each read port uses a request/valid/ready handshake.
- It consumes the writes produced by the write-enabled register path and serves operand reads to the datapath, for example the decode stage reading rs/rt.
- Read data is snapshotted into output registers and held stable while the consumer stalls.

---
 rtl/reg_file_read_port_pair.sv | 120 ++++++++++++
 tb/tb_reg_file_read_port_pair.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_read_port_pair.sv
// rtl/reg_file_read_port_pair.sv - 2^A x W register file, one write port, two handshaked registered read ports
module reg_file_read_port_pair #(
    parameter int W       = 8,
    parameter int A       = 4,
    parameter int ZERO_R0 = 1
) (
    input  logic         clk,
    input  logic         reset_asynchronous,
    input  logic         write_enable,
    input  logic [A-1:0] write_addr,
    input  logic [W-1:0] write_data,
    input  logic         rd_req_a,
    input  logic [A-1:0] rd_addr_a,
    output logic         rd_req_ready_a,
    output logic         rd_valid_a,
    input  logic         rd_ready_a,
    output logic [W-1:0] rd_data_a,
    input  logic         rd_req_b,
    input  logic [A-1:0] rd_addr_b,
    output logic         rd_req_ready_b,
    output logic         rd_valid_b,
    input  logic         rd_ready_b,
    output logic [W-1:0] rd_data_b
);

    localparam int DEPTH = 1 << A;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_t;

    logic [W-1:0] regs [DEPTH];
    port_state_t  state_a, state_a_next;
    port_state_t  state_b, state_b_next;
    logic         accept_a, accept_b;
    logic         write_kept;
    logic [W-1:0] read_val_a, read_val_b;

    assign write_kept = write_enable && !((ZERO_R0 != 0) && (write_addr == '0));

    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_kept) begin
            regs[write_addr] <= write_data;
        end
    end

    // Write-first bypass; the hardwired zero register overrides even the bypass.
    always_comb begin
        read_val_a = regs[rd_addr_a];
        if (write_enable && (write_addr == rd_addr_a)) begin
            read_val_a = write_data;
        end
        if ((ZERO_R0 != 0) && (rd_addr_a == '0)) begin
            read_val_a = '0;
        end
    end

    always_comb begin
        read_val_b = regs[rd_addr_b];
        if (write_enable && (write_addr == rd_addr_b)) begin
            read_val_b = write_data;
        end
        if ((ZERO_R0 != 0) && (rd_addr_b == '0)) begin
            read_val_b = '0;
        end
    end

    assign rd_valid_a     = (state_a == FULL);
    assign rd_valid_b     = (state_b == FULL);
    assign rd_req_ready_a = !rd_valid_a || rd_ready_a;
    assign rd_req_ready_b = !rd_valid_b || rd_ready_b;

    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            state_a <= EMPTY;
            state_b <= EMPTY;
        end else begin
            state_a <= state_a_next;
            state_b <= state_b_next;
        end
    end

    always_comb begin
        accept_a     = rd_req_a && rd_req_ready_a;
        accept_b     = rd_req_b && rd_req_ready_b;
        state_a_next = state_a;
        state_b_next = state_b;
        if (accept_a) begin
            state_a_next = FULL;
        end else if (state_a == FULL && rd_ready_a) begin
            state_a_next = EMPTY;
        end
        if (accept_b) begin
            state_b_next = FULL;
        end else if (state_b == FULL && rd_ready_b) begin
            state_b_next = EMPTY;
        end
    end

    // Data is a snapshot taken only on accept, so stalls and drains leave it untouched.
    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            if (accept_a) begin
                rd_data_a <= read_val_a;
            end
            if (accept_b) begin
                rd_data_b <= read_val_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_read_port_pair.sv
// tb/tb_reg_file_read_port_pair.sv - self-checking bench for reg_file_read_port_pair
module tb_reg_file_read_port_pair;

    logic       clk = 1'b0;
    logic       reset_asynchronous;
    logic       write_enable;
    logic [3:0] write_addr;
    logic [7:0] write_data;
    logic       rd_req_a, rd_req_b;
    logic [3:0] rd_addr_a, rd_addr_b;
    logic       rd_req_ready_a, rd_req_ready_b;
    logic       rd_valid_a, rd_valid_b;
    logic       rd_ready_a, rd_ready_b;
    logic [7:0] rd_data_a, rd_data_b;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural register contents and what each port presents.
    logic [7:0] ref_mem [16];
    logic       ref_valid [2];
    logic [7:0] ref_data [2];

    reg_file_read_port_pair #(.W(8), .A(4), .ZERO_R0(1)) dut (
        .clk(clk),
        .reset_asynchronous(reset_asynchronous),
        .write_enable(write_enable),
        .write_addr(write_addr),
        .write_data(write_data),
        .rd_req_a(rd_req_a),
        .rd_addr_a(rd_addr_a),
        .rd_req_ready_a(rd_req_ready_a),
        .rd_valid_a(rd_valid_a),
        .rd_ready_a(rd_ready_a),
        .rd_data_a(rd_data_a),
        .rd_req_b(rd_req_b),
        .rd_addr_b(rd_addr_b),
        .rd_req_ready_b(rd_req_ready_b),
        .rd_valid_b(rd_valid_b),
        .rd_ready_b(rd_ready_b),
        .rd_data_b(rd_data_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] ref_read(input logic [3:0] addr);
        if (addr == 4'd0) return 8'h00;
        if (write_enable && write_addr == addr) return write_data;
        return ref_mem[addr];
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        for (int p = 0; p < 2; p++) begin
            ref_valid[p] = 1'b0;
            ref_data[p]  = 8'h00;
        end
    endtask

    task automatic idle();
        write_enable = 1'b0; write_addr = 4'd0; write_data = 8'h00;
        rd_req_a = 1'b0; rd_addr_a = 4'd0; rd_ready_a = 1'b1;
        rd_req_b = 1'b0; rd_addr_b = 4'd0; rd_ready_b = 1'b1;
    endtask

    // One clock: predict from the inputs now applied, clock, then compare at the falling edge.
    task automatic tick();
        logic       req [2];
        logic       rdy [2];
        logic [3:0] adr [2];
        logic       nv [2];
        logic [7:0] nd [2];
        req[0] = rd_req_a; rdy[0] = rd_ready_a; adr[0] = rd_addr_a;
        req[1] = rd_req_b; rdy[1] = rd_ready_b; adr[1] = rd_addr_b;
        #1;
        chk("req_ready_a", 8'(rd_req_ready_a), 8'(!ref_valid[0] || rdy[0]));
        chk("req_ready_b", 8'(rd_req_ready_b), 8'(!ref_valid[1] || rdy[1]));
        for (int p = 0; p < 2; p++) begin
            nv[p] = ref_valid[p];
            nd[p] = ref_data[p];
            if (req[p] && (!ref_valid[p] || rdy[p])) begin
                nv[p] = 1'b1;
                nd[p] = ref_read(adr[p]);
            end else if (rdy[p]) begin
                nv[p] = 1'b0;
            end
        end
        @(posedge clk);
        if (write_enable && write_addr != 4'd0) ref_mem[write_addr] = write_data;
        for (int p = 0; p < 2; p++) begin
            ref_valid[p] = nv[p];
            ref_data[p]  = nd[p];
        end
        @(negedge clk);
        chk("valid_a", 8'(rd_valid_a), 8'(ref_valid[0]));
        chk("data_a", rd_data_a, ref_data[0]);
        chk("valid_b", 8'(rd_valid_b), 8'(ref_valid[1]));
        chk("data_b", rd_data_b, ref_data[1]);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        idle();
        write_enable = 1'b1; write_addr = addr; write_data = data;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset_asynchronous = 1'b1;
        ref_reset();
        #2;
        chk("rst_valid_a", 8'(rd_valid_a), 8'h00);
        chk("rst_data_a", rd_data_a, 8'h00);
        chk("rst_valid_b", 8'(rd_valid_b), 8'h00);
        chk("rst_data_b", rd_data_b, 8'h00);
        @(negedge clk);
        reset_asynchronous = 1'b0;

        // Write r3 and scan the whole file through port A.
        wr(4'd3, 8'h5A);
        for (int i = 0; i < 16; i++) begin
            idle();
            rd_req_a = 1'b1; rd_addr_a = 4'(i);
            tick();
            chk("scan_valid", 8'(rd_valid_a), 8'h01);
            chk("scan_data", rd_data_a, (i == 3) ? 8'h5A : 8'h00);
        end
        idle(); tick();

        // Same-cycle write with both ports reading the same address.
        wr(4'd7, 8'h11);
        write_enable = 1'b1; write_addr = 4'd7; write_data = 8'hC3;
        rd_req_a = 1'b1; rd_addr_a = 4'd7;
        rd_req_b = 1'b1; rd_addr_b = 4'd7;
        tick();
        chk("bypass_a", rd_data_a, 8'hC3);
        chk("bypass_b", rd_data_b, 8'hC3);
        idle(); tick();

        // Stall on port A: snapshot holds across a write, request not taken.
        wr(4'd2, 8'h10);
        rd_req_a = 1'b1; rd_addr_a = 4'd2; rd_ready_a = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            write_enable = (i == 0); write_addr = 4'd2; write_data = 8'h20;
            tick();
            chk("hold_valid", 8'(rd_valid_a), 8'h01);
            chk("hold_data", rd_data_a, 8'h10);
        end
        write_enable = 1'b0;
        rd_ready_a = 1'b1;
        tick();
        chk("release_data", rd_data_a, 8'h20);
        idle(); tick();

        // Hardwired zero register, plain and with same-cycle bypass.
        wr(4'd0, 8'hFF);
        rd_req_b = 1'b1; rd_addr_b = 4'd0;
        tick();
        chk("r0_b", rd_data_b, 8'h00);
        write_enable = 1'b1; write_addr = 4'd0; write_data = 8'hFF;
        tick();
        chk("r0_bypass_b", rd_data_b, 8'h00);
        chk("r0_bypass_valid", 8'(rd_valid_b), 8'h01);
        idle(); tick();

        // Port B stalled on r5 while port A streams r1..r4.
        for (int i = 1; i <= 5; i++) wr(4'(i), 8'(i));
        wr(4'd5, 8'h55);
        rd_req_b = 1'b1; rd_addr_b = 4'd5; rd_ready_b = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            rd_req_a = 1'b1; rd_addr_a = 4'(i); rd_ready_a = 1'b1;
            tick();
            chk("b2b_data_a", rd_data_a, 8'(i));
            chk("b2b_held_b", rd_data_b, 8'h55);
        end
        rd_req_a = 1'b0;
        tick();
        chk("drain_valid_a", 8'(rd_valid_a), 8'h00);
        chk("drain_data_a", rd_data_a, 8'h04);
        idle(); tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            write_enable = 1'($urandom);
            write_addr   = 4'($urandom);
            write_data   = 8'($urandom);
            rd_req_a     = 1'($urandom);
            rd_addr_a    = ($urandom_range(0, 3) == 0) ? write_addr : 4'($urandom);
            rd_ready_a   = ($urandom_range(0, 3) != 0);
            rd_req_b     = 1'($urandom);
            rd_addr_b    = ($urandom_range(0, 3) == 0) ? rd_addr_a : 4'($urandom);
            rd_ready_b   = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Asynchronous reset between edges while port A holds data.
        idle();
        wr(4'd9, 8'h99);
        rd_req_a = 1'b1; rd_addr_a = 4'd9; rd_ready_a = 1'b0;
        tick();
        chk("pre_rst_valid", 8'(rd_valid_a), 8'h01);
        rd_req_a = 1'b0;
        #2;
        reset_asynchronous = 1'b1;
        #1;
        chk("async_rst_valid_a", 8'(rd_valid_a), 8'h00);
        chk("async_rst_data_a", rd_data_a, 8'h00);
        ref_reset();
        @(negedge clk);
        reset_asynchronous = 1'b0;
        idle();
        tick();
        for (int i = 0; i < 16; i++) begin
            idle();
            rd_req_a = 1'b1; rd_addr_a = 4'(i);
            tick();
            chk("post_rst_data", rd_data_a, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
